// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with PC-tagged FIFO and redirect flush
// Optional statistics counters enabled by defining IFU_STATS_EN.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFU_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [15:0] stat_flushed
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t        state, state_next;
    logic          req_next;
    logic [31:0]   addr_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   target;
    logic [31:0]   seq_pc;
    logic          handshake;
    logic          push;
    logic          pop;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_if_push;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign seq_pc    = imem_addr + 32'd4;
    assign handshake = imem_req && imem_ack;

    // A flush discards the whole buffer, so a pop in the flush cycle must not move rd_ptr.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : 32'd0;

    assign count_if_push = count - CW'(pop) + CW'(1);

    always_comb begin
        state_next    = state;
        req_next      = imem_req;
        addr_next     = imem_addr;
        fetch_pc_next = fetch_pc;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = target;
                end else if (count < CW'(DEPTH)) begin
                    req_next   = 1'b1;
                    addr_next  = fetch_pc;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_next = target;
                    if (handshake) begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = DROP;
                    end
                end else if (handshake) begin
                    push          = 1'b1;
                    fetch_pc_next = seq_pc;
                    if (count_if_push < CW'(DEPTH)) begin
                        addr_next = seq_pc;
                    end else begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_next = target;
                end
                if (handshake) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
            fetch_pc  <= fetch_pc_next;
            if (redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= imem_addr;
        end
    end

`ifdef IFU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (push && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (redirect && (stat_flushed != '1)) begin
                stat_flushed <= stat_flushed + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFU_STATS_EN
    logic [31:0] stat_fetched;
    logic [15:0] stat_flushed;
`endif

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    int lat_cnt  = 0;
    logic ack_force;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef IFU_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_flushed(stat_flushed)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack arrives after lat wait cycles of an outstanding request.
    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = ack_force | (imem_req && (lat_cnt >= lat));

    always @(posedge clk) begin
        if (rst) lat_cnt <= 0;
        else if (imem_req && imem_ack) lat_cnt <= 0;
        else if (imem_req) lat_cnt <= lat_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        ack_force   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) step();
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        out_ready = 1'b0;
        lat       = 0;
        do_reset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc",    out_pc, 32'h0);
`ifdef IFU_STATS_EN
        check("rst_stat_fetched", stat_fetched, 32'd0);
        check("rst_stat_flushed", {16'd0, stat_flushed}, 32'd0);
`endif

        // streaming with zero-latency memory and decode always ready
        out_ready = 1'b1;
        step();
        check("seq_req0",  {31'd0, imem_req}, 32'd1);
        check("seq_addr0", imem_addr, 32'h0);
        check("seq_valid0", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("seq_addr%0d", k), imem_addr, 32'(4 * k));
            check($sformatf("seq_pc%0d", k), out_pc, 32'(4 * (k - 1)));
            check($sformatf("seq_instr%0d", k), out_instr, mem_word(32'(4 * (k - 1))));
        end

        // decode stalled: buffer fills to 4, fetch stops, then drains in order
        do_reset();
        out_ready = 1'b0;
        step();
        repeat (4) step();
        check("full_req",   {31'd0, imem_req}, 32'd0);
        check("full_valid", {31'd0, out_valid}, 32'd1);
        check("full_pc",    out_pc, 32'h0);
        check("full_instr", out_instr, mem_word(32'h0));
        step();
        step();
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_pc",  out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        check("drain_pc1",  out_pc, 32'h4);
        check("drain_req1", {31'd0, imem_req}, 32'd0);
        step();
        check("drain_pc2",   out_pc, 32'h8);
        check("drain_req2",  {31'd0, imem_req}, 32'd1);
        check("drain_addr2", imem_addr, 32'h10);
        step();
        check("drain_pc3", out_pc, 32'hC);
        step();
        check("drain_pc4",    out_pc, 32'h10);
        check("drain_instr4", out_instr, mem_word(32'h10));

        // 3-cycle memory, redirect while the request to 0x8 is outstanding
        do_reset();
        out_ready = 1'b1;
        lat       = 2;
        repeat (7) step();
        check("drop_addr_pre", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("drop_addr_hold", imem_addr, 32'h8);
        check("drop_req_hold",  {31'd0, imem_req}, 32'd1);
        check("drop_flushed",   {31'd0, out_valid}, 32'd0);
        step();
        check("drop_addr_hold2", imem_addr, 32'h8);
        step();
        check("drop_req_idle",   {31'd0, imem_req}, 32'd0);
        check("drop_valid_idle", {31'd0, out_valid}, 32'd0);
        step();
        check("drop_new_req",  {31'd0, imem_req}, 32'd1);
        check("drop_new_addr", imem_addr, 32'h200);
        wait_valid("drop_wait_valid", 10);
        check("drop_first_pc",    out_pc, 32'h200);
        check("drop_first_instr", out_instr, mem_word(32'h200));

        // redirect coinciding with ack and pop
        do_reset();
        out_ready = 1'b1;
        lat       = 0;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("flush_old_head", out_pc, 32'h0);
        step();
        redirect = 1'b0;
        check("flush_empty", {31'd0, out_valid}, 32'd0);
        check("flush_noreq", {31'd0, imem_req}, 32'd0);
        step();
        check("flush_addr", imem_addr, 32'h40);
        step();
        check("flush_pc",    out_pc, 32'h40);
        check("flush_instr", out_instr, mem_word(32'h40));

        // wrap-around and alignment of redirect targets
        do_reset();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap_idle", {31'd0, imem_req}, 32'd0);
        step();
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr_zero", imem_addr, 32'h0);
        check("wrap_pc",        out_pc, 32'hFFFF_FFFC);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        step();
        check("align_addr", imem_addr, 32'h100);
`ifdef IFU_STATS_EN
        check("stat_flushed_two", {16'd0, stat_flushed}, 32'd2);
        check("stat_fetched_one", stat_fetched, 32'd1);
`endif

        // reset in the middle of an outstanding request with 2 entries buffered
        do_reset();
        out_ready = 1'b0;
        lat       = 0;
        repeat (3) step();
        check("mid_req_before", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_req",   {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc",    out_pc, 32'h0);
        rst       = 1'b0;
        ack_force = 1'b1;
        step();
        ack_force = 1'b0;
        check("stale_valid", {31'd0, out_valid}, 32'd0);
        check("stale_addr",  imem_addr, 32'h0);
        check("stale_req",   {31'd0, imem_req}, 32'd1);
        step();
        check("restart_pc",    out_pc, 32'h0);
        check("restart_instr", out_instr, mem_word(32'h0));
`ifdef IFU_STATS_EN
        check("stat_fetched_after_rst", stat_fetched, 32'd1);
        check("stat_flushed_after_rst", {16'd0, stat_flushed}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decode, control-unit and register-file path.
- Generates sequential word addresses and fetches instructions from a variable-latency instruction memory port.
- Buffers fetched words, each with its PC, in a small FIFO that decode drains through a valid/ready handshake.
- Accepts redirects from the branch, jump and jr next-PC logic; a redirect flushes the buffer and restarts fetch at the new target.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect  input  1  next-PC override from branch/jump/jr resolution.
- redirect_pc  input  32  redirect target; bits [1:0] are forced to 0.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; word-aligned.
- imem_ack  input  1  memory completes the request this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ack is high.
- out_valid  output  1  FIFO head holds an instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction.
- out_pc  output  32  address of the head instruction.

Behaviour:
- Reset (rst high at a clock edge):
  - FIFO count = 0; out_valid = 0.
  - imem_req = 0; imem_addr = RESET_PC; fetch_pc = RESET_PC.
  - state = IDLE.
  - out_instr and out_pc read 0.
  - rst overrides every other input, including mid-transaction; any late imem_ack after reset is ignored.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the response will be kept.
  - DROP: request outstanding; the response will be discarded.
- Memory protocol:
  - imem_req and imem_addr are registered outputs.
  - Once imem_req rises, imem_req and imem_addr stay stable until a cycle with imem_req && imem_ack. A request is never abandoned.
  - imem_ack is legal in the first cycle of the request; minimum transfer length is 1 cycle.
- Transitions:
  - IDLE -> WAIT when count < DEPTH and no redirect this cycle. The request is asserted with imem_addr = fetch_pc.
  - IDLE with redirect: fetch_pc <= redirect_pc and state stays IDLE. The request is issued the next cycle.
  - WAIT, ack, no redirect:
    - Push {imem_rdata, imem_addr}; fetch_pc <= imem_addr + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
    - If count after this cycle's push/pop is < DEPTH, stay in WAIT and assert the next request back-to-back in the following cycle. Otherwise go to IDLE.
  - WAIT, redirect, no ack: state -> DROP; fetch_pc <= redirect_pc.
  - WAIT, redirect and ack in the same cycle: the data is discarded, fetch_pc <= redirect_pc, state -> IDLE.
  - DROP, ack: discard the data, state -> IDLE. fetch_pc already holds the target.
  - DROP, redirect: fetch_pc <= newest redirect_pc. A redirect coinciding with the ack also wins.
- FIFO:
  - out_valid = (count != 0). out_instr and out_pc are taken from the head entry combinationally.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is issued only with guaranteed space.
- Flush: a redirect sets count <= 0 next cycle. A pop in that same cycle is ignored for ordering, but out_instr and out_pc remain the old head for that cycle.
- Latency: redirect at edge N gives imem_req to the target at edge N+1 (from IDLE), and the earliest out_valid at edge N+2 with zero-latency memory.

Optional Feature:
- Macro: IFU_STATS_EN.
- When defined, adds the following ports and behaviour:
  - stat_fetched output 32: increments on every pushed word.
  - stat_flushed output 16: increments on every redirect.
  - Both counters saturate at all-ones and clear on rst.
- When undefined, these ports and counters are absent. Functional behaviour is identical in both builds.

Test Plan:
- Reset, ack tied high, out_ready high -> imem_addr sequence 0,4,8,...; out_pc trails by one cycle and out_instr matches the memory model.
- out_ready=0, zero-latency memory, DEPTH=4 -> exactly 4 pushes (0,4,8,C); then imem_req=0 and out_valid holds PC 0. Raising out_ready drains in order and fetch resumes at 0x10.
- 3-cycle memory latency, redirect to 0x200 in the cycle after req to 0x8 -> imem_addr stays 0x8 until ack; that word is discarded; next request to 0x200; no 0x8 appears on out_pc.
- Redirect to 0x40 coinciding with ack and with a pop -> FIFO empty next cycle; next request to 0x40; first out_pc = 0x40.
- Redirect to 0xFFFF_FFFC -> fetch wraps to 0x0000_0000; redirect_pc 0x103 -> imem_addr 0x100.
- rst asserted while WAIT with 2 entries buffered -> next cycle out_valid=0, imem_req=0; stale ack ignored; fetch restarts at RESET_PC. With IFU_STATS_EN, the counters read 0 after reset and stat_flushed increments once per redirect.
